// File: rtl/fpu_sequencer.sv
// fpu_sequencer
//   Issue/complete sequencer for a non-pipelined FP datapath. One operation is
//   outstanding at a time. It is accepted in IDLE and counted down in EXEC for
//   the unit latency. In WB it is written back to the FP register file, or to
//   the FP condition flag for c.eq. Sticky IEEE exception flags are
//   accumulated on completion.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready issue handshake; req_op (3b), req_fd (5b)
//   op_latch, unit_sel  operand-capture pulse and datapath select
//   res_data/status/aeqb datapath result, status byte and compare result
//   wb_valid/wb_ready   write-back handshake; wb_fd, wb_data
//   cond_we, cond_val   FP condition-flag write (c.eq)
//   busy, busy_fd       hazard info for decode
//   flush               cancel in-flight op / block acceptance
//   flags, flags_clr    sticky {invalid, divzero, overflow, underflow, inexact}
module fpu_sequencer #(
  parameter int LAT_ADD = 2,
  parameter int LAT_MUL = 3,
  parameter int LAT_DIV = 10,
  parameter int LAT_CMP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [4:0]  req_fd,
  output logic        op_latch,
  output logic [2:0]  unit_sel,
  input  logic [31:0] res_data,
  input  logic [7:0]  res_status,
  input  logic        res_aeqb,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_fd,
  output logic [31:0] wb_data,
  output logic        cond_we,
  output logic        cond_val,
  output logic        busy,
  output logic [4:0]  busy_fd,
  input  logic        flush,
  output logic [4:0]  flags,
  input  logic        flags_clr
);

  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_CMP = 3'b100;

  localparam int LAT_M1  = (LAT_ADD > LAT_MUL) ? LAT_ADD : LAT_MUL;
  localparam int LAT_M2  = (LAT_DIV > LAT_CMP) ? LAT_DIV : LAT_CMP;
  localparam int LAT_MAX = (LAT_M1 > LAT_M2) ? LAT_M1 : LAT_M2;
  // The counter holds at most LAT_MAX-1.
  localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2:0]         op_q;
  logic [4:0]         fd_q;
  logic [31:0]        data_q;
  logic [4:0]         fbits_q;
  logic               aeqb_q;
  logic [4:0]         flags_q;
  logic [4:0]         flags_d;

  logic accept;
  logic in_wb;
  logic wb_is_cmp;
  logic complete;
  logic unused_status;

  // Codes 101-111 fall through to the add latency.
  function automatic logic [CNT_W-1:0] lat_load(input logic [2:0] op);
    case (op)
      OP_MUL:  return CNT_W'(LAT_MUL - 1);
      OP_DIV:  return CNT_W'(LAT_DIV - 1);
      OP_CMP:  return CNT_W'(LAT_CMP - 1);
      default: return CNT_W'(LAT_ADD - 1);
    endcase
  endfunction

  // Map the datapath status byte to the sticky flag layout. Divide-by-zero
  // only counts when the operation really was a divide.
  function automatic logic [4:0] status_flags(input logic [7:0] st, input logic [2:0] op);
    return {st[2], st[7] && (op == OP_DIV), st[4], st[3], st[5]};
  endfunction

  // Status bits 0, 1 and 6 carry no flag meaning here.
  assign unused_status = ^{res_status[6], res_status[1:0]};

  assign req_ready = !rst && (state_q == S_IDLE) && !flush;
  assign accept    = req_valid && req_ready;
  assign op_latch  = accept;

  assign in_wb     = (state_q == S_WB);
  assign wb_is_cmp = (op_q == OP_CMP);

  // Flush squashes the write-back in the same cycle so no handshake can slip
  // through while the sequencer is being cancelled.
  assign wb_valid  = !rst && in_wb && !wb_is_cmp && !flush;
  assign cond_we   = !rst && in_wb && wb_is_cmp && !flush;
  assign cond_val  = cond_we && aeqb_q;
  assign complete  = (wb_valid && wb_ready) || cond_we;

  assign busy      = !rst && (state_q != S_IDLE);
  assign busy_fd   = busy ? fd_q : 5'd0;
  assign wb_fd     = fd_q;
  assign wb_data   = rst ? 32'd0 : data_q;
  assign flags     = flags_q;

  always_comb begin
    unit_sel = 3'b000;
    if (!rst) begin
      if (state_q != S_IDLE) unit_sel = op_q;
      else if (accept)       unit_sel = req_op;
    end
  end

  // A clear and a completion in the same cycle: the new bits win.
  assign flags_d = (flags_clr ? 5'd0 : flags_q) | (complete ? fbits_q : 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= 3'd0;
      fd_q    <= 5'd0;
      data_q  <= 32'd0;
      fbits_q <= 5'd0;
      aeqb_q  <= 1'b0;
      flags_q <= 5'd0;
    end else begin
      flags_q <= flags_d;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q    <= req_op;
            fd_q    <= req_fd;
            cnt_q   <= lat_load(req_op);
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (flush) begin
            state_q <= S_IDLE;
          end else if (cnt_q == '0) begin
            data_q  <= res_data;
            fbits_q <= status_flags(res_status, op_q);
            aeqb_q  <= res_aeqb;
            state_q <= S_WB;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_WB: begin
          // c.eq leaves after its single write cycle; arithmetic waits for wb_ready.
          if (flush || wb_is_cmp || wb_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fpu_sequencer.md
FPU_SEQUENCER -- requirements
Module: fpu_sequencer

Interface
REQ-001 SHALL have parameter LAT_ADD, default 2: cycles of execution for add/sub.
REQ-002 SHALL have parameter LAT_MUL, default 3: cycles of execution for mul.
REQ-003 SHALL have parameter LAT_DIV, default 10: cycles of execution for div.
REQ-004 SHALL have parameter LAT_CMP, default 1: cycles of execution for c.eq; every LAT SHALL be at least 1.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have ports req_valid (input, 1), req_ready (output, 1): issue handshake from decode.
REQ-008 SHALL have port req_op, input, 3 bits: 000 add, 001 sub, 010 mul, 011 div, 100 c.eq; 101-111 are treated as add.
REQ-009 SHALL have port req_fd, input, 5 bits: destination FP register.
REQ-010 SHALL have ports op_latch (output, 1) and unit_sel (output, 3): operand-capture pulse and datapath select.
REQ-011 SHALL have ports res_data (input, 32), res_status (input, 8) and res_aeqb (input, 1): datapath result, status and compare outputs.
REQ-012 SHALL have ports wb_valid (output, 1), wb_ready (input, 1), wb_fd (output, 5) and wb_data (output, 32): FP register-file write-back handshake.
REQ-013 SHALL have ports cond_we (output, 1) and cond_val (output, 1): FP condition-flag write.
REQ-014 SHALL have ports busy (output, 1) and busy_fd (output, 5): hazard information for decode.
REQ-015 SHALL have port flush, input, 1 bit: cancels any in-flight operation.
REQ-016 SHALL have ports flags (output, 5) and flags_clr (input, 1): sticky {invalid, divzero, overflow, underflow, inexact}.

Function
REQ-017 SHALL implement FSM states IDLE, EXEC and WB.
REQ-018 SHALL drive req_ready = (state==IDLE) && !flush.
REQ-019 On accept at cycle T (req_valid && req_ready): SHALL pulse op_latch in cycle T, register op/fd, load cnt = LAT(op)-1, and go to EXEC.
REQ-020 unit_sel SHALL equal req_op in cycle T and the registered op in EXEC/WB; it SHALL be 000 in IDLE otherwise.
REQ-021 In EXEC, cnt SHALL decrement each cycle; at cnt==0 SHALL sample res_data, res_status and res_aeqb, then go to WB; EXEC therefore lasts exactly LAT cycles.
REQ-022 WB for an arithmetic op: wb_valid=1 from cycle T+LAT+1, with wb_fd and wb_data stable until wb_ready; on handshake SHALL go to IDLE.
REQ-023 WB for c.eq: SHALL assert cond_we=1 and cond_val=sampled aeqb for exactly one cycle, wb_valid=0, then go to IDLE unconditionally.
REQ-024 Flags SHALL be OR-updated only in the completion cycle (wb handshake, or the c.eq WB cycle), as follows:
  - invalid = status[2]
  - divzero = status[7] && op==div
  - overflow = status[4]
  - underflow = status[3]
  - inexact = status[5]
REQ-025 flags_clr SHALL zero flags; if a completion occurs in the same cycle, the new bits SHALL survive the clear.
REQ-026 flush in EXEC or WB SHALL force IDLE next cycle with no wb_valid handshake, no cond_we and no flag update; flush in IDLE SHALL block acceptance.
REQ-027 The datapath is not pipelined: at most one operation SHALL be outstanding, and a new request SHALL only be accepted in IDLE.
REQ-028 busy SHALL equal (state!=IDLE); busy_fd SHALL be the registered fd when busy, else 0.
REQ-029 wb_ready held low SHALL stall in WB indefinitely, with outputs unchanged.

Reset
REQ-030 rst SHALL have priority over all inputs, flush included.
REQ-031 rst high at a rising edge SHALL set state=IDLE, cnt=0, flags=0 and registered op/fd/data=0.
REQ-032 While in reset: req_ready=0, wb_valid=0, cond_we=0, op_latch=0, busy=0, busy_fd=0, unit_sel=000, wb_data=0.
REQ-033 rst asserted mid-EXEC or mid-WB SHALL discard the operation silently.

Verification
REQ-034 Add, default params: accept op=000 fd=5 at cycle 10, res_data=0x40400000, wb_ready=1 -> op_latch at 10, busy 11-13, wb_valid=1 with wb_fd=5 and wb_data=0x40400000 at cycle 13, req_ready=1 at 14.
REQ-035 Divide by zero: div, res_status=0x80, wb_ready=1 -> wb_valid 11 cycles after accept, flags=5'b01000; then flags_clr -> flags=0.
REQ-036 Compare: c.eq with res_aeqb=1 -> cond_we=1 and cond_val=1 for exactly one cycle, 2 cycles after accept, with wb_valid never asserted.
REQ-037 Backpressure: mul with wb_ready=0 for 5 cycles -> wb_valid and wb_data held constant, req_ready=0 throughout, handshake on the 6th cycle.
REQ-038 Flush: flush in the 2nd EXEC cycle of a div with status=0x04 -> IDLE next cycle, no wb_valid, flags remain 0.
REQ-039 Reset mid-operation: rst in WB with wb_ready=0 -> next cycle all outputs at reset values; a new add is accepted the cycle after rst deasserts.
